// File: rtl/time_display_scan.sv
// Snapshot a calendar clock's fields, convert them to BCD with one shared
// shift-add-3 engine, and scan the six resulting digits onto a 7-segment display.
module time_display_scan #(
   parameter int SCAN_DIV = 4
) (
   input  logic        clk,
   input  logic        res,
   input  logic [5:0]  sec,
   input  logic [5:0]  min,
   input  logic [4:0]  hr,
   input  logic [4:0]  dd,
   input  logic [3:0]  mm,
   input  logic [11:0] yy,
   input  logic        mode,
   input  logic        upd,
   output logic        busy,
   output logic        valid,
   output logic [5:0]  digit_sel,
   output logic [3:0]  bcd,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam logic [1:0]  S_IDLE  = 2'd0;
   localparam logic [1:0]  S_LOAD  = 2'd1;
   localparam logic [1:0]  S_SHIFT = 2'd2;
   localparam logic [1:0]  S_STORE = 2'd3;
   localparam logic [15:0] PRESC_MAX = 16'(SCAN_DIV - 1);

   logic [1:0]  state_q, state_d;
   logic [1:0]  fld_q, fld_d;
   logic [3:0]  bit_q, bit_d;
   logic        valid_q, valid_d;
   logic [23:0] disp_q, disp_d;
   logic [15:0] presc_q, presc_d;
   logic [2:0]  idx_q, idx_d;

   // Conversion datapath: snapshot fields, shift register, per-field results.
   logic [11:0] f0_q, f1_q, f2_q, f0_d, f1_d, f2_d;
   logic [27:0] sh_q, sh_d;
   logic [7:0]  t0_q, t1_q, t2_q, t0_d, t1_d, t2_d;

   logic [11:0] field_cur;
   logic [15:0] adj;
   logic [27:0] shifted;

   // One double-dabble step: add 3 to every BCD digit >= 5, then shift left.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      adj = sh_q[27:12];
      for (int i = 0; i < 4; i++) begin
         if (sh_q[12 + 4*i +: 4] >= 4'd5) adj[4*i +: 4] = sh_q[12 + 4*i +: 4] + 4'd3;
      end
      shifted = {adj, sh_q[11:0]} << 1;
   end

   always_comb begin
      case (fld_q)
         2'd0:    field_cur = f0_q;
         2'd1:    field_cur = f1_q;
         default: field_cur = f2_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      fld_d   = fld_q;
      bit_d   = bit_q;
      valid_d = valid_q;
      disp_d  = disp_q;
      f0_d    = f0_q;
      f1_d    = f1_q;
      f2_d    = f2_q;
      sh_d    = sh_q;
      t0_d    = t0_q;
      t1_d    = t1_q;
      t2_d    = t2_q;
      case (state_q)
         S_IDLE: begin
            if (upd) begin
               // Field order puts the rightmost display pair first in both modes.
               f0_d    = mode ? yy : {6'b0, sec};
               f1_d    = mode ? {8'b0, mm} : {6'b0, min};
               f2_d    = mode ? {7'b0, dd} : {7'b0, hr};
               fld_d   = 2'd0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            sh_d    = {16'b0, field_cur};
            bit_d   = 4'd0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            sh_d  = shifted;
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd11) begin
               case (fld_q)
                  2'd0:    t0_d = shifted[19:12];
                  2'd1:    t1_d = shifted[19:12];
                  default: t2_d = shifted[19:12];
               endcase
               if (fld_q == 2'd2) begin
                  state_d = S_STORE;
               end else begin
                  fld_d   = fld_q + 2'd1;
                  state_d = S_LOAD;
               end
            end
         end
         default: begin
            // Atomic commit, so the scan never mixes old and new frames.
            disp_d  = {t2_q, t1_q, t0_q};
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      presc_d = presc_q + 16'd1;
      idx_d   = idx_q;
      if (presc_q == PRESC_MAX) begin
         presc_d = 16'd0;
         idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (res) begin
         state_q <= S_IDLE;
         fld_q   <= 2'd0;
         bit_q   <= 4'd0;
         valid_q <= 1'b0;
         disp_q  <= 24'd0;
         presc_q <= 16'd0;
         idx_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         fld_q   <= fld_d;
         bit_q   <= bit_d;
         valid_q <= valid_d;
         disp_q  <= disp_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
      end
   end

   // NOTE: datapath storage is left unreset; it is always written before it is read.
   always_ff @(posedge clk) begin
      f0_q <= f0_d;
      f1_q <= f1_d;
      f2_q <= f2_d;
      sh_q <= sh_d;
      t0_q <= t0_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
   end

   logic [3:0] digit_cur;

   always_comb begin
      digit_sel = 6'b000001;
      digit_cur = disp_q[3:0];
      case (idx_q)
         3'd1: begin digit_sel = 6'b000010; digit_cur = disp_q[7:4];   end
         3'd2: begin digit_sel = 6'b000100; digit_cur = disp_q[11:8];  end
         3'd3: begin digit_sel = 6'b001000; digit_cur = disp_q[15:12]; end
         3'd4: begin digit_sel = 6'b010000; digit_cur = disp_q[19:16]; end
         3'd5: begin digit_sel = 6'b100000; digit_cur = disp_q[23:20]; end
         default: ;
      endcase
   end

   always_comb begin
      bcd = valid_q ? digit_cur : 4'd0;
      seg = 7'h00;
      if (valid_q) begin
         case (digit_cur)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = 7'h00;
         endcase
      end
      dp = valid_q && (idx_q == 3'd2 || idx_q == 3'd4);
   end

   assign busy  = (state_q != S_IDLE);
   assign valid = valid_q;

endmodule

// File: doc/time_display_scan.md
Name: time_display_scan

Overview:
Reader and display side of the calendar clock counter. On request it takes a snapshot of the binary time/date fields (sec, min, hr, dd, mm, yy), converts them to BCD with a shared sequential shift-add-3 engine, and holds the six digits in a display buffer. A free-running scan multiplexes those digits onto a 7-segment display.

Parameters:
SCAN_DIV, 4, clk cycles each digit stays selected (legal range 1..65535)

Ports:
clk  input  1  system clock
res  input  1  synchronous reset, active-high
sec  input  6  seconds, binary
min  input  6  minutes, binary
hr  input  5  hours, binary
dd  input  5  day of month, binary
mm  input  4  month, binary
yy  input  12  year, binary
mode  input  1  0 = time (HH MM SS), 1 = date (DD MM YY)
upd  input  1  single-cycle snapshot/convert request
busy  output  1  conversion in progress
valid  output  1  display buffer holds a completed conversion
digit_sel  output  6  one-hot digit enable, bit0 = rightmost digit
bcd  output  4  BCD value of the selected digit
seg  output  7  active-high segments {g,f,e,d,c,b,a}
dp  output  1  separator decimal point

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, res).
- Reset values: busy=0, valid=0, digit_sel=6'b000001, bcd=0, seg=0, dp=0. Display buffer cleared, prescaler=0, FSM=IDLE.
- FSM states: IDLE, LOAD, SHIFT, STORE.
  - IDLE: upd=1 at edge k captures mode and all six field inputs into snapshot registers. busy goes high at edge k.
  - The three fields are converted in turn: (sec,min,hr) in time mode, (yy,mm,dd) in date mode.
  - Each field is zero-extended to 12 bits and converted by 12 shift-add-3 steps.
- Latency is fixed: busy falls at edge k+40. The new display buffer and valid=1 also take effect at edge k+40. The implementation pads to exactly 40 cycles.
- The display buffer is written atomically at completion, so the scan never shows a mixed old/new frame.
- upd while busy=1 is ignored: not queued, does not extend busy.
- Field inputs are sampled only at edge k; later input changes do not affect the conversion in progress.
- Digit mapping uses the two least-significant BCD digits of each field:
  - Time mode: idx0/1 = sec units/tens, idx2/3 = min units/tens, idx4/5 = hr units/tens.
  - Date mode: idx0/1 = yy units/tens (yy mod 100), idx2/3 = mm, idx4/5 = dd.
- Out-of-range values are displayed as-is, with no clamping: hr=31 shows "31", sec=63 shows "63", yy=4095 shows "95".
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and the digit index advances, wrapping 5 to 0. digit_sel is the one-hot form of the index.
  - SCAN_DIV=1 advances the index every cycle.
  - The scan runs continuously, independent of busy/valid.
- Output decode:
  - bcd, seg and dp are combinational from the digit index and display buffer, so they change in the same cycle as digit_sel.
  - seg codes: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - dp=1 at idx2 and idx4 when valid=1.
  - valid=0 forces bcd=0, seg=0, dp=0.
- Reset mid-conversion aborts the conversion: busy=0, valid=0, buffer cleared at that edge. A later upd behaves normally.
- upd and res asserted in the same cycle: res wins and upd is dropped.

Test Plan:
1. res high 10 cycles, then low -> digit_sel=000001, busy=0, valid=0, seg=00; with SCAN_DIV=4, digit_sel shifts left every 4 cycles and wraps 100000->000001.
2. mode=0, hr=13, min=45, sec=7, upd pulse at edge k -> busy=1 from k to k+39, 0 at k+40, valid=1 at k+40. Scan idx0..5 gives bcd 7,0,5,4,3,1 and seg 07,3F,6D,66,4F,06; dp=1 only at idx2 and idx4.
3. mode=1, dd=29, mm=2, yy=2024, upd -> bcd idx0..5 = 4,2,2,0,9,2 after 40 cycles.
4. mode=0, hr=31, min=0, sec=63, then mode=1, yy=4095 -> "31 00 63", then idx0/1 = 5,9.
5. upd at k with sec=7, then change sec=59 and pulse upd at k+10 -> second upd ignored; busy falls at k+40; display shows 07.
6. After test 2 completes, upd at k, res at k+20 -> busy=0, valid=0, seg=00 at k+20; new upd at k+25 completes at k+65 with the new snapshot.
